// File: rtl/aes_key_expand.sv
// aes_key_expand: iterative AES key schedule, one 32-bit word per cycle, round keys streamed over valid/ready
// Ports: clk, rst (async, active-high); i_start/i_key/i_key_len request an expansion (sampled in IDLE);
//   o_rk/o_rk_idx/o_rk_valid + i_rk_ready stream round keys 0..Nr; o_busy, o_done and o_err report status.
// Option: `define AES_KEY_EXP_LONG_EN adds AES-192/256 (8-word buffer, Nk==8 SubWord step); default is AES-128 only.
module aes_key_expand #(
  parameter int KEY_W = 256,
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [KEY_W-1:0] i_key,
  input  logic [1:0]       i_key_len,
  output logic             o_busy,
  output logic             o_rk_valid,
  input  logic             i_rk_ready,
  output logic [127:0]     o_rk,
  output logic [IDX_W-1:0] o_rk_idx,
  output logic             o_done,
  output logic             o_err
);
`ifdef AES_KEY_EXP_LONG_EN
  localparam int NW = 8;
`else
  localparam int NW = 4;
`endif
  localparam int AW = $clog2(NW);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state;
  logic [31:0] wbuf [0:NW-1];
  logic [31:0] kw [0:NW-1];
  logic [95:0] acc;
  logic [5:0] i;
  logic [AW-1:0] p, nkm1, nkm1_new;
  logic [3:0] nr, nr_new;
  logic [7:0] rcon;
  logic [31:0] prev, sw, t, w_new;
  logic legal, init_w, more, hs, adv;
  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction
  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
  for (genvar g = 0; g < NW; g++) begin : g_kw
    assign kw[g] = i_key[KEY_W-1-32*g -: 32];
  end
`ifdef AES_KEY_EXP_LONG_EN
  assign legal    = i_key_len != 2'd3;
  assign nkm1_new = i_key_len == 2'd0 ? 3'd3 : i_key_len == 2'd1 ? 3'd5 : 3'd7;
  assign nr_new   = i_key_len == 2'd0 ? 4'd10 : i_key_len == 2'd1 ? 4'd12 : 4'd14;
  assign t        = p == '0 ? sw ^ {rcon, 24'h0} : (nkm1 == 3'd7 && p == 3'd4) ? sw : prev;
`else
  logic key_unused;
  assign key_unused = ^i_key;
  assign legal    = i_key_len == 2'd0;
  assign nkm1_new = 2'd3;
  assign nr_new   = 4'd10;
  assign t        = p == '0 ? sw ^ {rcon, 24'h0} : prev;
`endif
  // wbuf[0] holds w[i-1]; w[i-Nk] sits at position Nk-1, which also walks the key words out first
  assign prev   = wbuf[0];
  assign sw     = subword(p == '0 ? {prev[23:0], prev[31:24]} : prev);
  assign init_w = i <= 6'(nkm1);
  assign w_new  = init_w ? wbuf[nkm1] : wbuf[nkm1] ^ t;
  assign more   = i != {nr + 4'd1, 2'b00};
  assign hs     = o_rk_valid && i_rk_ready;
  assign adv    = !o_rk_valid || i_rk_ready;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= IDLE;
      o_busy     <= 1'b0;
      o_rk_valid <= 1'b0;
      o_rk       <= '0;
      o_rk_idx   <= '0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
      acc        <= '0;
      i          <= '0;
      p          <= '0;
      nkm1       <= '0;
      nr         <= '0;
      rcon       <= '0;
      for (int m = 0; m < NW; m++) wbuf[m] <= '0;
    end else begin
      o_err  <= 1'b0;
      o_done <= 1'b0;
      case (state)
        IDLE:
          if (i_start && legal) begin
            state  <= EXPAND;
            o_busy <= 1'b1;
            nkm1   <= nkm1_new;
            nr     <= nr_new;
            i      <= '0;
            p      <= '0;
            rcon   <= 8'h01;
            for (int m = 0; m < NW; m++) wbuf[m] <= AW'(m) <= nkm1_new ? kw[nkm1_new - AW'(m)] : '0;
          end else if (i_start) o_err <= 1'b1;
        EXPAND:
          if (hs && o_rk_idx == IDX_W'(nr)) begin
            state      <= DONE;
            o_rk_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b1;
          end else if (adv) begin
            o_rk_valid <= 1'b0;
            if (more) begin
              i       <= i + 6'd1;
              p       <= p == nkm1 ? '0 : p + 1'b1;
              wbuf[0] <= w_new;
              for (int m = 1; m < NW; m++) wbuf[m] <= wbuf[m-1];
              if (!init_w && p == '0) rcon <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
              if (i[1:0] == 2'b11) begin
                o_rk       <= {acc, w_new};
                o_rk_idx   <= IDX_W'(i[5:2]);
                o_rk_valid <= 1'b1;
              end else acc <= {acc[63:0], w_new};
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand: directed checks of aes_key_expand against FIPS-197 key-expansion vectors
module tb_aes_key_expand;
  logic clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_rk_ready = 1'b0;
  logic [255:0] i_key = '0;
  logic [1:0] i_key_len = '0;
  logic o_busy, o_rk_valid, o_done, o_err;
  logic [127:0] o_rk;
  logic [3:0] o_rk_idx;
  int n_chk = 0, n_fail = 0, n;
  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] KEY256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  logic [127:0] rk128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  always #5 clk = ~clk;
  aes_key_expand dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_key(i_key), .i_key_len(i_key_len),
    .o_busy(o_busy), .o_rk_valid(o_rk_valid), .i_rk_ready(i_rk_ready), .o_rk(o_rk),
    .o_rk_idx(o_rk_idx), .o_done(o_done), .o_err(o_err)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run_hi(input logic [1:0] len, input logic [255:0] key, input int nr,
                        input logic [127:0] first, input logic [127:0] last, input bit all, input bit poke);
    i_key = key;
    i_key_len = len;
    i_rk_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("busy_on", o_busy, 1);
    chk("valid_early", o_rk_valid, 0);
    for (int c = 1; c <= 4 * nr + 4; c++) begin
      if (poke && c == 8) begin
        i_start = 1'b1;
        i_key_len = 2'd3;
        i_key = '1;
      end
      if (poke && c == 9) i_start = 1'b0;
      tick();
      if (poke && (c == 8 || c == 9)) chk("mid_start_err", o_err, 0);
      if (c % 4 == 0) begin
        chk("rk_valid", o_rk_valid, 1);
        chk("rk_idx", o_rk_idx, c / 4 - 1);
        if (all) chk("rk128", o_rk, rk128[c/4-1]);
        else if (c == 4) chk("rk_first", o_rk, first);
        else if (c == 4 * nr + 4) chk("rk_last", o_rk, last);
      end else chk("valid_gap", o_rk_valid, 0);
    end
    tick();
    chk("done_pulse", o_done, 1);
    chk("busy_off", o_busy, 0);
    chk("valid_off", o_rk_valid, 0);
    tick();
    chk("done_clear", o_done, 0);
  endtask
  initial begin
    tick();
    tick();
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_rk_valid, 0);
    chk("rst_rk", o_rk, 0);
    chk("rst_idx", o_rk_idx, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    rst = 1'b0;
    tick();
    run_hi(2'd0, KEY128, 10, rk128[0], rk128[10], 1'b1, 1'b0);
    i_key_len = 2'd3;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("ill3_err", o_err, 1);
    chk("ill3_busy", o_busy, 0);
    tick();
    chk("ill3_err_clear", o_err, 0);
    chk("ill3_busy_idle", o_busy, 0);
`ifdef AES_KEY_EXP_LONG_EN
    run_hi(2'd1, KEY192, 12, 128'h8e73b0f7da0e6452c810f32b809079e5,
           128'he98ba06f448c773c8ecc720401002202, 1'b0, 1'b0);
    run_hi(2'd2, KEY256, 14, 128'h603deb1015ca71be2b73aef0857d7781,
           128'hfe4890d1e6188d0b046df344706c631e, 1'b0, 1'b0);
    i_key = KEY256;
    i_key_len = 2'd2;
`else
    i_key_len = 2'd2;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    chk("short_only_err", o_err, 1);
    chk("short_only_busy", o_busy, 0);
    tick();
    i_key = KEY128;
    i_key_len = 2'd0;
`endif
    i_rk_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 0; c < 16; c++) tick();
    chk("pre_rst_valid", o_rk_valid, 1);
    chk("pre_rst_idx", o_rk_idx, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", o_busy, 0);
    chk("abort_valid", o_rk_valid, 0);
    chk("abort_rk", o_rk, 0);
    chk("abort_idx", o_rk_idx, 0);
    chk("abort_done", o_done, 0);
    chk("abort_err", o_err, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_done", o_done, 0);
    chk("post_rst_busy", o_busy, 0);
    run_hi(2'd0, KEY128, 10, rk128[0], rk128[10], 1'b1, 1'b1);
    i_key = KEY128;
    i_key_len = 2'd0;
    i_rk_ready = 1'b0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 0;
    for (int c = 0; c < 400 && n < 11; c++) begin
      i_rk_ready = 1'($urandom_range(0, 1));
      if (o_rk_valid && i_rk_ready) begin
        chk("bp_rk", o_rk, rk128[n]);
        chk("bp_idx", o_rk_idx, n);
        n++;
        tick();
      end else if (o_rk_valid) begin
        tick();
        chk("bp_stall_valid", o_rk_valid, 1);
        chk("bp_stall_rk", o_rk, rk128[n]);
        chk("bp_stall_idx", o_rk_idx, n);
      end else tick();
    end
    chk("bp_count", n, 11);
    chk("bp_done", o_done, 1);
    chk("bp_busy_off", o_busy, 0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
